// File: rtl/keypad_link.sv
// Remote-panel end of the alarm link: status-frame deserializer driving LEDs,
// plus debounced 4-button keypad. Optional link watchdog: KEYPAD_LINK_WATCHDOG_EN.
module keypad_link #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int LINK_TIMEOUT    = 32
) (
    input  logic       SERCLK_OUT,
    input  logic       RESET_IN,
    input  logic       STATUS_OUT,
    input  logic       STATUS_SEND,
    input  logic [3:0] KEY_BTN,
    output logic [1:0] KB_IN,
    output logic       KB_RECV,
    output logic       LED_ARMED,
    output logic       LED_ALARM,
    output logic       LED_S1,
    output logic       LED_S2,
    output logic       FRAME_VALID,
    output logic       LINK_LOST
);

    typedef enum logic [1:0] {K_IDLE, K_EMIT, K_RELEASE} key_state_t;
    typedef enum logic       {R_IDLE, R_SHIFT}            rx_state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  r_sync1, r_sync2, r_stable;
    logic [15:0] r_cnt [4];

    // NOTE: every per-button counter is reset explicitly; a press held through
    // reset must start its debounce from zero, not from leftover state.
    always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= KEY_BTN;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_stable[i] <= ~r_stable[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    key_state_t r_key_state, w_key_next;
    logic [1:0] w_low_idx, r_kb_in;

    always_comb begin
        w_low_idx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (r_stable[i]) w_low_idx = 2'(i);
    end

    always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
        if (RESET_IN) r_key_state <= K_IDLE;
        else          r_key_state <= w_key_next;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        w_key_next = r_key_state;
        case (r_key_state)
            K_IDLE:    if (|r_stable) w_key_next = K_EMIT;
            K_EMIT:    w_key_next = K_RELEASE;
            K_RELEASE: if (r_stable == 4'd0) w_key_next = K_IDLE;
            default:   w_key_next = K_IDLE;
        endcase
    end

    always_comb begin
        KB_RECV = (r_key_state == K_EMIT);
    end

    // Code is latched on the edge entering K_EMIT so it is valid with the strobe.
    always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
        if (RESET_IN)                                r_kb_in <= 2'd0;
        else if (r_key_state == K_IDLE && |r_stable) r_kb_in <= w_low_idx;
    end

    assign KB_IN = r_kb_in;

    rx_state_t  r_rx_state, w_rx_next;
    logic [1:0] r_bit_cnt;
    logic [2:0] r_word;
    logic [3:0] r_led;
    logic       r_frame_valid;
    logic       w_shift_bit, w_done;

    always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
        if (RESET_IN) r_rx_state <= R_IDLE;
        else          r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            R_IDLE:  if (STATUS_SEND) w_rx_next = R_SHIFT;
            R_SHIFT: if (!STATUS_SEND && r_bit_cnt == 2'd3) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_shift_bit = (r_rx_state == R_SHIFT) && !STATUS_SEND;
        w_done      = w_shift_bit && (r_bit_cnt == 2'd3);
    end

    // STATUS_SEND always wins, so a re-assertion mid-frame restarts at bit 3.
    always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_bit_cnt     <= 2'd0;
            r_word        <= 3'd0;
            r_led         <= 4'd0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_done;
            if (STATUS_SEND) begin
                r_word    <= {2'b00, STATUS_OUT};
                r_bit_cnt <= 2'd1;
            end else if (w_shift_bit) begin
                r_word    <= {r_word[1:0], STATUS_OUT};
                r_bit_cnt <= r_bit_cnt + 2'd1;
            end
            if (w_done) r_led <= {r_word, STATUS_OUT};
        end
    end

    assign FRAME_VALID = r_frame_valid;

    logic w_lost;

`ifdef KEYPAD_LINK_WATCHDOG_EN
    localparam logic [15:0] WD_MAX = 16'(LINK_TIMEOUT);
    logic [15:0] r_wd_cnt;
    logic        r_link_lost;

    always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_wd_cnt    <= '0;
            r_link_lost <= 1'b0;
        end else begin
            if (STATUS_SEND)           r_wd_cnt <= '0;
            else if (r_wd_cnt != WD_MAX) r_wd_cnt <= r_wd_cnt + 16'd1;
            if (w_done)                  r_link_lost <= 1'b0;
            else if (r_wd_cnt == WD_MAX) r_link_lost <= 1'b1;
        end
    end

    assign w_lost = r_link_lost;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (LINK_TIMEOUT == 0);
    assign w_lost           = 1'b0;
`endif

    // Fail-safe: a lost link shows only the alarm LED.
    assign LED_ARMED = r_led[3] & ~w_lost;
    assign LED_ALARM = r_led[2] |  w_lost;
    assign LED_S1    = r_led[1] & ~w_lost;
    assign LED_S2    = r_led[0] & ~w_lost;
    assign LINK_LOST = w_lost;

endmodule

// File: tb/tb_keypad_link.sv
// Directed self-checking bench for keypad_link (default build; the watchdog
// section runs when KEYPAD_LINK_WATCHDOG_EN is defined).
module tb_keypad_link;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       status_out = 1'b0;
    logic       status_send = 1'b0;
    logic [3:0] key_btn = 4'd0;
    logic [1:0] kb_in;
    logic       kb_recv, led_armed, led_alarm, led_s1, led_s2, frame_valid, link_lost;

    int n_cmp = 0;
    int n_mis = 0;
    int kb_cnt = 0;
    int fv_cnt = 0;
    logic kb_prev = 1'b0;
    logic kb_double = 1'b0;
    int kb_mark;

    keypad_link #(.DEBOUNCE_CYCLES(8), .LINK_TIMEOUT(32)) dut (
        .SERCLK_OUT (clk),
        .RESET_IN   (rst),
        .STATUS_OUT (status_out),
        .STATUS_SEND(status_send),
        .KEY_BTN    (key_btn),
        .KB_IN      (kb_in),
        .KB_RECV    (kb_recv),
        .LED_ARMED  (led_armed),
        .LED_ALARM  (led_alarm),
        .LED_S1     (led_s1),
        .LED_S2     (led_s2),
        .FRAME_VALID(frame_valid),
        .LINK_LOST  (link_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kb_recv && kb_prev) kb_double = 1'b1;
        kb_prev = kb_recv;
        if (kb_recv) kb_cnt++;
        if (frame_valid) fv_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] leds();
        return {led_armed, led_alarm, led_s1, led_s2};
    endfunction

    // Drives n bits MSB first, STATUS_SEND high with the first; returns just after
    // the negedge following the last sampling edge.
    task automatic send_bits(input logic [3:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            status_send = (i == 0);
            status_out  = bits[3-i];
            @(negedge clk);
        end
        status_send = 1'b0;
        status_out  = 1'b0;
    endtask

    task automatic hold_expect(input int n, input int at, input logic [1:0] code);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            chk($sformatf("kb_recv@%0d", i), {7'd0, kb_recv}, {7'd0, i == at});
            if (i == at) chk("kb_in@strobe", {6'd0, kb_in}, {6'd0, code});
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_kb_in", {6'd0, kb_in}, 8'd0);
        chk("rst_kb_recv", {7'd0, kb_recv}, 8'd0);
        chk("rst_leds", {4'd0, leds()}, 8'd0);
        chk("rst_fv", {7'd0, frame_valid}, 8'd0);
        chk("rst_lost", {7'd0, link_lost}, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1,0,1,1
        send_bits(4'b1011, 4);
        chk("f1_leds", {4'd0, leds()}, 8'h0B);
        chk("f1_fv", {7'd0, frame_valid}, 8'd1);
        @(negedge clk);
        chk("f1_fv_off", {7'd0, frame_valid}, 8'd0);

        // Complete 1,1,0,0; partial 2 bits; restart with 0,1,0,0
        send_bits(4'b1100, 4);
        chk("f2_leds", {4'd0, leds()}, 8'h0C);
        send_bits(4'b0011, 2);
        chk("abort_leds", {4'd0, leds()}, 8'h0C);
        chk("abort_fv", {7'd0, frame_valid}, 8'd0);
        send_bits(4'b0100, 4);
        chk("f3_leds", {4'd0, leds()}, 8'h04);
        chk("f3_fv", {7'd0, frame_valid}, 8'd1);
        @(negedge clk);
        chk("fv_count_a", 8'(fv_cnt), 8'd3);

        // Key 1 held 20 cycles: single strobe at cycle 11
        key_btn = 4'b0010;
        hold_expect(20, 11, 2'd1);
        key_btn = 4'b0000;
        repeat (12) @(negedge clk);
        chk("kb_in_hold", {6'd0, kb_in}, 8'd1);

        // 5-cycle glitch on key 3: no event
        kb_mark = kb_cnt;
        key_btn = 4'b1000;
        repeat (5) @(negedge clk);
        key_btn = 4'b0000;
        repeat (15) @(negedge clk);
        chk("glitch_strobes", 8'(kb_cnt - kb_mark), 8'd0);

        // Keys 2 and 3 together: lower index wins
        kb_mark = kb_cnt;
        key_btn = 4'b1100;
        hold_expect(14, 11, 2'd2);
        key_btn = 4'b0000;
        repeat (12) @(negedge clk);
        chk("dual_strobes", 8'(kb_cnt - kb_mark), 8'd1);

        // Reset mid-frame while key 3 held
        key_btn = 4'b1000;
        hold_expect(14, 11, 2'd3);
        send_bits(4'b1111, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_kb_in", {6'd0, kb_in}, 8'd0);
        chk("mid_rst_leds", {4'd0, leds()}, 8'd0);
        chk("mid_rst_recv", {7'd0, kb_recv}, 8'd0);
        chk("mid_rst_fv", {7'd0, frame_valid}, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold_expect(14, 11, 2'd3);
        chk("post_rst_leds", {4'd0, leds()}, 8'd0);
        key_btn = 4'b0000;
        send_bits(4'b1001, 4);
        chk("post_rst_frame", {4'd0, leds()}, 8'h09);
        chk("post_rst_fv", {7'd0, frame_valid}, 8'd1);
        repeat (12) @(negedge clk);

`ifdef KEYPAD_LINK_WATCHDOG_EN
        repeat (40) @(negedge clk);
        chk("wd_lost", {7'd0, link_lost}, 8'd1);
        chk("wd_leds", {4'd0, leds()}, 8'h04);
        send_bits(4'b1011, 4);
        chk("wd_clear", {7'd0, link_lost}, 8'd0);
        chk("wd_frame_leds", {4'd0, leds()}, 8'h0B);
        @(negedge clk);
        chk("fv_count_b", 8'(fv_cnt), 8'd5);
`else
        chk("fv_count_b", 8'(fv_cnt), 8'd4);
`endif
        chk("no_double_strobe", {7'd0, kb_double}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/keypad_link.md
# keypad_link

Remote-panel side of the alarm controller's link. It deserializes the 4-bit status frame carried on STATUS_SEND/STATUS_OUT and drives the panel LEDs. It also debounces the four panel buttons and emits one 2-bit key symbol per press on KB_IN, with a one-cycle KB_RECV strobe, for the controller's code checker. Clock and link signals are shared with the main controller; the block runs entirely in the SERCLK_OUT domain.

## Interface
- DEBOUNCE_CYCLES, 8: consecutive synchronized samples that differ from the stable state before a button's stable state flips; range 1..65535.
- LINK_TIMEOUT, 32: maximum cycles between STATUS_SEND assertions before LINK_LOST; only used with the macro in Configuration.
- SERCLK_OUT  in  1  link clock; all logic on its rising edge.
- RESET_IN  in  1  reset, asynchronous, active-high.
- STATUS_OUT  in  1  serial status bit, MSB first.
- STATUS_SEND  in  1  frame start; high during the bit-3 cycle.
- KEY_BTN  in  4  raw buttons, active-high, asynchronous; index = key code.
- KB_IN  out  2  code of the last accepted key; held until the next press.
- KB_RECV  out  1  one-cycle strobe; KB_IN is valid while it is high.
- LED_ARMED, LED_ALARM, LED_S1, LED_S2  out  1 each  frame bits 3, 2, 1, 0 of the last complete frame.
- FRAME_VALID  out  1  one-cycle pulse per complete frame.
- LINK_LOST  out  1  status-frame timeout flag.

## Operation
- Reset values: KB_IN=0, KB_RECV=0, all LEDs 0, FRAME_VALID=0, LINK_LOST=0. Button stable states and debounce counters are 0. Both FSMs go to their idle states.
- Button path, per bit:
  - 2-flop synchronizer.
  - 16-bit counter: clears when the synced value equals the stable state; increments otherwise. On reaching DEBOUNCE_CYCLES the stable state flips and the counter clears.
- Key FSM:
  - K_IDLE -> K_EMIT when any stable bit rises.
  - K_EMIT: KB_RECV=1 for one cycle, KB_IN = lowest set stable index. Always proceeds to K_RELEASE.
  - K_RELEASE -> K_IDLE only when all four stable bits are 0.
  - No repeat while held. Presses of other keys during K_RELEASE are ignored.
- Frame FSM:
  - R_IDLE: on a sampled STATUS_SEND=1, capture STATUS_OUT as bit 3, set count=1, go to R_SHIFT.
  - R_SHIFT: capture one bit per cycle, MSB first. When the 4th bit is captured, load LEDs from the assembled word, pulse FRAME_VALID, and return to R_IDLE.
  - STATUS_SEND=1 while in R_SHIFT discards the partial frame and restarts with this bit as bit 3.
  - LEDs change only on complete frames. A partial frame never alters them.
- Simultaneous events: the key and frame paths are independent, and a key strobe and FRAME_VALID may coincide. If two buttons become stable on the same edge, the lower index wins and the other is dropped.
- Reset mid-frame or mid-press: the partial frame is dropped, LEDs are 0, and a button still held after reset yields one press once debounced.

## Timing
- Button held stable from its first sampling edge: the stable state flips 2+DEBOUNCE_CYCLES edges later, and KB_RECV is high in the following cycle. Total latency is 3+DEBOUNCE_CYCLES cycles.
- Glitch shorter than DEBOUNCE_CYCLES synced samples: no event.
- Frame: bits are sampled on edges E0..E3, with STATUS_SEND high at E0. LEDs update at E3. FRAME_VALID is high for exactly the cycle following E3.
- Back-to-back frames (STATUS_SEND again at E4) are accepted; with the controller's 3-cycle standby a frame arrives every 7 cycles.
- KB_RECV is never high on two consecutive cycles.

## Configuration
- KEYPAD_LINK_WATCHDOG_EN defined:
  - A counter clears on every sampled STATUS_SEND=1 and otherwise increments, saturating.
  - LINK_LOST is set when the counter reaches LINK_TIMEOUT and clears on the next completed frame.
  - While LINK_LOST=1 all LEDs are forced to 0 and LED_ALARM is forced to 1 (fail-safe indication).
- Not defined: no counter is built, LINK_LOST is tied to 0, and LEDs always reflect the last frame.

## Test plan
- Frame, STATUS_SEND at E0 with bits 1,0,1,1 -> at E3 LED_ARMED=1, LED_ALARM=0, LED_S1=1, LED_S2=1; one FRAME_VALID pulse.
- Frame of 1,1,0,0, then STATUS_SEND re-asserted after 2 bits with 0,1,0,0 -> LEDs go 1,1,0,0, then 0,1,0,0; one FRAME_VALID per complete frame, none for the aborted one.
- KEY_BTN=4'b0010 held 20 cycles, DEBOUNCE_CYCLES=8 -> a single KB_RECV at cycle 11 with KB_IN=1; no further strobe until release.
- KEY_BTN[3] pulsed high for 5 cycles -> no KB_RECV. KEY_BTN=4'b1100 pressed on the same edge -> one strobe with KB_IN=2.
- RESET_IN asserted mid-frame and during a held press -> all outputs 0 immediately; after release of reset, one KB_RECV for the still-held key; next full frame sets the LEDs.
- With KEYPAD_LINK_WATCHDOG_EN: no STATUS_SEND for 32 cycles -> LINK_LOST=1, LED_ALARM=1, other LEDs 0; next complete frame -> LINK_LOST=0 and LEDs equal frame bits.
